// File: rtl/syzygy_dac_spi_target.sv
// AD911x-style 3-wire SPI configuration target with a 32 x 8 register file.
// Define SZG_DAC_SPI_TGT_MULTIBYTE_EN to accept N = 1..3 (2..4 data bytes per frame).
module syzygy_dac_spi_target #(
    parameter int          SYNC_STAGES    = 2,
    parameter logic [31:0] READ_ONLY_MASK = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dac_sclk,
    input  logic       dac_cs_n,
    inout  wire        dac_sdio,
    input  logic       dac_reset,
    output logic       spi_wr_strobe,
    output logic [4:0] spi_wr_addr,
    output logic [7:0] spi_wr_data,
    output logic       spi_rd_strobe,
    output logic       frame_err,
    output logic       busy,
    input  logic [4:0] host_addr,
    output logic [7:0] host_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INSTR,
        ST_DATA,
        ST_DONE,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdio_sync, rst_sync;
    logic                   sclk_p0, cs_p0, sdio_p0, rst_p0;
    logic                   sclk_p1, cs_p1;
    logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t      state, state_nxt;
    logic        err_nxt, instr_done, byte_done, n_ok;
    logic [7:0]  instr_byte;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt, n_lat;
    logic [7:0]  shift_in, shift_out;
    logic        rw;
    logic [4:0]  addr;
    logic        sdio_oe, sdio_out;
    logic [7:0]  regs [32];

    // Synchronizer stage (p0) and one-cycle delay for edge detection (p1)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync <= '1;
            cs_sync   <= '1;
            sdio_sync <= '0;
            rst_sync  <= '0;
            sclk_p1   <= 1'b1;
            cs_p1     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], dac_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], dac_cs_n};
            sdio_sync <= {sdio_sync[SYNC_STAGES-2:0], dac_sdio};
            rst_sync  <= {rst_sync[SYNC_STAGES-2:0], dac_reset};
            sclk_p1   <= sclk_p0;
            cs_p1     <= cs_p0;
        end
    end

    assign sclk_p0   = sclk_sync[SYNC_STAGES-1];
    assign cs_p0     = cs_sync[SYNC_STAGES-1];
    assign sdio_p0   = sdio_sync[SYNC_STAGES-1];
    assign rst_p0    = rst_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_p0 & ~sclk_p1;
    assign sclk_fall = ~sclk_p0 & sclk_p1;
    assign cs_rise   = cs_p0 & ~cs_p1;
    assign cs_fall   = ~cs_p0 & cs_p1;
    assign busy      = ~cs_p0;

    // The byte as it stands including the bit sampled on this rise
    assign instr_byte = {shift_in[6:0], sdio_p0};

`ifdef SZG_DAC_SPI_TGT_MULTIBYTE_EN
    assign n_ok = 1'b1;
`else
    assign n_ok = (instr_byte[6:5] == 2'b00);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        err_nxt    = 1'b0;
        instr_done = 1'b0;
        byte_done  = 1'b0;
        if (rst_p0) begin
            state_nxt = ST_IDLE;
        end else if (cs_rise) begin
            state_nxt = ST_IDLE;
            err_nxt   = (state == ST_INSTR) || (state == ST_DATA) || (state == ST_IGNORE);
        end else begin
            case (state)
                ST_IDLE: if (cs_fall) state_nxt = ST_INSTR;
                ST_INSTR: begin
                    if (sclk_rise && bit_cnt == 3'd7) begin
                        instr_done = 1'b1;
                        state_nxt  = n_ok ? ST_DATA : ST_IGNORE;
                    end
                end
                ST_DATA: begin
                    if (sclk_rise && bit_cnt == 3'd7) begin
                        byte_done = 1'b1;
                        if (byte_cnt == n_lat) state_nxt = ST_DONE;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Shift/commit stage: register file, read shifter and registered strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            n_lat         <= '0;
            shift_in      <= '0;
            shift_out     <= '0;
            rw            <= 1'b0;
            addr          <= '0;
            sdio_oe       <= 1'b0;
            sdio_out      <= 1'b0;
            spi_wr_strobe <= 1'b0;
            spi_wr_addr   <= '0;
            spi_wr_data   <= '0;
            spi_rd_strobe <= 1'b0;
            frame_err     <= 1'b0;
            host_data     <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            spi_wr_strobe <= 1'b0;
            spi_rd_strobe <= 1'b0;
            frame_err     <= err_nxt;
            host_data     <= regs[host_addr];
            if (rst_p0) begin
                sdio_oe <= 1'b0;
                for (int i = 0; i < 32; i++) regs[i] <= '0;
            end else begin
                if (state == ST_IDLE) begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                end
                if (sclk_rise && (state == ST_INSTR || state == ST_DATA)) begin
                    shift_in <= instr_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                end
                if (instr_done) begin
                    rw    <= instr_byte[7];
                    n_lat <= instr_byte[6:5];
                    addr  <= instr_byte[4:0];
                    if (instr_byte[7] && n_ok) begin
                        shift_out     <= regs[instr_byte[4:0]];
                        spi_rd_strobe <= 1'b1;
                    end
                end
                if (byte_done) begin
                    addr     <= addr - 5'd1;
                    byte_cnt <= byte_cnt + 2'd1;
                    if (!rw) begin
                        if (!READ_ONLY_MASK[addr]) begin
                            regs[addr]    <= instr_byte;
                            spi_wr_strobe <= 1'b1;
                            spi_wr_addr   <= addr;
                            spi_wr_data   <= instr_byte;
                        end
                    end else if (byte_cnt != n_lat) begin
                        shift_out     <= regs[addr - 5'd1];
                        spi_rd_strobe <= 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (state == ST_DATA && rw) begin
                        sdio_oe   <= 1'b1;
                        sdio_out  <= shift_out[7];
                        shift_out <= {shift_out[6:0], 1'b0};
                    end else begin
                        sdio_oe <= 1'b0;
                    end
                end
                if (cs_rise) sdio_oe <= 1'b0;
            end
        end
    end

    assign dac_sdio = sdio_oe ? sdio_out : 1'bz;

endmodule
